imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the asynchronous-read instruction ROM (imem).
- Owns the PC, drives the ROM word address and captures the returned instruction into a registered output stage.
- Presents instructions to decode over a valid/ready handshake.
- Supports start, halt, redirect (branch/jump) and a sticky misalignment error.

Parameters:
- ADDR_WIDTH, 10, ROM word-address width; ROM depth is 2^ADDR_WIDTH words.
- DATA_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, byte PC loaded at reset.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  pulse; IDLE/HALT -> RUN.
- halt_req  in  1  pulse; RUN -> HALT.
- redirect_valid  in  1  load a new PC and flush the output stage.
- redirect_pc  in  32  target byte address.
- imem_addr  out  ADDR_WIDTH  ROM word address, equal to pc[ADDR_WIDTH+1:2], combinational from the pc register.
- imem_inst  in  DATA_WIDTH  ROM read data, same cycle.
- out_valid  out  1  out_pc/out_inst hold a valid instruction.
- out_ready  in  1  decode accepts the instruction.
- out_pc  out  32  PC of out_inst.
- out_inst  out  DATA_WIDTH  fetched instruction.
- busy  out  1  state == RUN.
- err  out  1  sticky misaligned-redirect error.

Behaviour:
- Reset (asynchronous, active-low):
  - state = IDLE, pc = RESET_PC.
  - out_valid = 0, out_pc = 0, out_inst = 0.
  - busy = 0, err = 0.
- States:
  - IDLE: no fetch. start -> RUN.
  - RUN: fetch active. halt_req -> HALT.
  - HALT: no fetch. start -> RUN and err clears.
- Load condition: state == RUN && (!out_valid || out_ready) && !redirect_valid.
- On load: out_valid <= 1, out_pc <= pc, out_inst <= imem_inst, pc <= pc + 4.
- Throughput and latency:
  - Back-to-back loads give one instruction per cycle at full throughput.
  - Latency from the edge that samples start: first out_valid is asserted after the next edge (2 edges total).
- Handshake:
  - While out_valid && !out_ready, out_pc, out_inst and pc hold stable.
  - out_valid drops only after acceptance with no new load, on redirect, or on reset.
- No-load cycle: if out_valid && out_ready and no load occurs (IDLE/HALT), out_valid <= 0.
- Redirect (highest priority, any state):
  - Aligned (redirect_pc[1:0] == 0): pc <= redirect_pc, out_valid <= 0. The state is unchanged, so IDLE can take a boot address. The next RUN load fetches the target.
  - Misaligned: pc is unchanged, out_valid <= 0, err <= 1, state <= HALT.
- halt_req in RUN: state <= HALT, no further loads. A pending out_valid is not flushed and completes its handshake normally. halt_req in IDLE or HALT is ignored.
- Simultaneous events:
  - redirect + halt_req in RUN: the redirect is applied, then HALT.
  - start + redirect in IDLE/HALT: both apply, so the first fetch is at redirect_pc.
  - start + halt_req in IDLE/HALT: start wins.
  - start in RUN is ignored.
- Wrap-around:
  - pc + 4 is modulo 2^32.
  - The ROM index wraps modulo 2^ADDR_WIDTH because PC bits above ADDR_WIDTH+1 are ignored.
- Mid-operation reset: all outputs return to reset values immediately. Any in-flight instruction is discarded.

Optional Feature:
- Macro: IMEM_FETCH_PERF_EN.
- Defined:
  - Adds output fetch_count[31:0], incremented on each out_valid && out_ready.
  - Saturates at 32'hFFFF_FFFF.
  - Cleared by reset and by start taken from IDLE; not cleared by start from HALT.
- Undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package imem_fetch_pkg:
  - enum fetch_state_e {IDLE, RUN, HALT}.
  - PC_WIDTH = 32.
  - INST_BYTES = 4.
- Sub-module: none required. The output register stage may be split into fetch_out_reg (valid/ready pipeline register), but the top-level behaviour must be identical.

Test Plan:
- ROM[0..3] = 0x11,0x22,0x33,0x44. Reset, pulse start, out_ready=1 -> out_valid rises 2 edges after start. Outputs (pc,inst) = (0,0x11),(4,0x22),(8,0x33) on consecutive cycles.
- Backpressure: hold out_ready=0 for 3 cycles while out_pc=4 -> out_pc=4 and out_inst=0x22 stable; imem_addr=2. Release -> next output is (8,0x33).
- Redirect to 0x100 while out_valid is high -> next cycle out_valid=0. The following output is (0x100, ROM[64]).
- Redirect to 0x102 -> err=1, busy=0, out_valid=0. A subsequent start -> err=0, fetch resumes at the PC held before the bad redirect.
- ADDR_WIDTH=10, redirect to 0xFFC then run -> fetches ROM[1023]. The next output has out_pc=0x1000 with inst=ROM[0] (index wrap).
- Assert rst_n low mid-stream with out_valid=1 -> out_valid, out_pc, out_inst = 0 and busy=0 asynchronously. With IMEM_FETCH_PERF_EN, fetch_count=0 and it counts exactly 5 after 5 accepted handshakes.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
//   fetch_state_e : sequencer state encoding (IDLE, RUN, HALT)
//   PC_WIDTH      : byte program-counter width
//   INST_BYTES    : bytes per instruction word (PC step)
//   pc_aligned()  : true when a byte PC is word aligned
package imem_fetch_pkg;

  localparam int unsigned PC_WIDTH   = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_e;

  // Instruction word alignment check on a byte PC.
  function automatic logic pc_aligned(input logic [PC_WIDTH-1:0] pc);
    return (pc[1:0] == 2'b00);
  endfunction

endpackage : imem_fetch_pkg

// File: rtl/imem_fetch_ctrl_out_reg.sv
// Valid/ready output register stage holding one fetched instruction.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   load               : capture in_pc/in_inst and assert out_valid
//   flush              : drop out_valid (wins over load)
//   in_pc, in_inst     : instruction being fetched this cycle
//   out_ready          : consumer accepts the held instruction
//   out_valid, out_pc, out_inst : registered output payload
module imem_fetch_ctrl_out_reg
  import imem_fetch_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  flush,
  input  logic [PC_WIDTH-1:0]   in_pc,
  input  logic [DATA_WIDTH-1:0] in_inst,
  input  logic                  out_ready,
  output logic                  out_valid,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0] out_inst
);

  // Payload only changes on load, so it holds while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_pc    <= '0;
      out_inst  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_pc    <= in_pc;
      out_inst  <= in_inst;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule : imem_fetch_ctrl_out_reg

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer for an asynchronous-read instruction ROM.
// Owns the PC, addresses the ROM, and registers each fetched word into a
// valid/ready output stage for decode. Supports start, halt, redirect and a
// sticky misaligned-redirect error.
// Optional: define IMEM_FETCH_PERF_EN to add the fetch_count output.
// Ports:
//   clk, rst_n                  : clock, async active-low reset
//   start, halt_req             : run control pulses
//   redirect_valid, redirect_pc : branch/jump target load (flushes output)
//   imem_addr                   : ROM word address (pc[ADDR_WIDTH+1:2])
//   imem_inst                   : ROM read data, same cycle
//   out_valid, out_ready        : output handshake
//   out_pc, out_inst            : PC and instruction presented to decode
//   busy                        : sequencer in RUN
//   err                         : sticky misaligned-redirect flag
//   fetch_count                 : accepted instructions (IMEM_FETCH_PERF_EN)
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter int unsigned         ADDR_WIDTH = 10,
  parameter int unsigned         DATA_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_inst,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [PC_WIDTH-1:0]   out_pc,
  output logic [DATA_WIDTH-1:0] out_inst,
  output logic                  busy,
  output logic                  err
`ifdef IMEM_FETCH_PERF_EN
  ,
  output logic [31:0]           fetch_count
`endif
);

  fetch_state_e          state_q, state_d;
  logic [PC_WIDTH-1:0]   pc_q, pc_d;
  logic                  err_d;
  logic                  load_c;
  logic                  flush_c;
  logic                  start_idle_c;
  logic                  redirect_ok_c;
  logic                  redirect_bad_c;

  // State, PC and error registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      err     <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err     <= err_d;
    end
  end

  // Next state, next PC, error and output-stage control.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    err_d          = err;
    load_c         = 1'b0;
    flush_c        = 1'b0;
    start_idle_c   = 1'b0;
    redirect_ok_c  = redirect_valid && pc_aligned(redirect_pc);
    redirect_bad_c = redirect_valid && !pc_aligned(redirect_pc);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = RUN;
          start_idle_c = 1'b1;
        end
      end
      RUN: begin
        if (halt_req) state_d = HALT;
      end
      HALT: begin
        if (start) begin
          state_d = RUN;
          err_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A redirect cycle never loads; the target is fetched on the next RUN cycle.
    load_c = (state_q == RUN) && (!out_valid || out_ready) && !redirect_valid;
    if (load_c) pc_d = pc_q + PC_WIDTH'(INST_BYTES);

    // Redirect overrides everything; a misaligned target parks the sequencer.
    if (redirect_valid) flush_c = 1'b1;
    if (redirect_ok_c)  pc_d    = redirect_pc;
    if (redirect_bad_c) begin
      err_d        = 1'b1;
      state_d      = HALT;
      start_idle_c = 1'b0;
    end
  end

  // Upper PC bits are ignored, so the ROM index wraps naturally.
  assign imem_addr = pc_q[ADDR_WIDTH+1:2];
  assign busy      = (state_q == RUN);

  imem_fetch_ctrl_out_reg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load_c),
    .flush     (flush_c),
    .in_pc     (pc_q),
    .in_inst   (imem_inst),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_pc    (out_pc),
    .out_inst  (out_inst)
  );

`ifdef IMEM_FETCH_PERF_EN
  // Saturating count of accepted instructions; restarts on a fresh boot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
    end else if (start_idle_c) begin
      fetch_count <= '0;
    end else if (out_valid && out_ready && (fetch_count != 32'hFFFF_FFFF)) begin
      fetch_count <= fetch_count + 32'd1;
    end
  end
`endif

endmodule : imem_fetch_ctrl

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          halt_req;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_inst;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [DW-1:0] out_inst;
  logic          busy;
  logic          err;
`ifdef IMEM_FETCH_PERF_EN
  logic [31:0]   fetch_count;
`endif

  logic [DW-1:0] rom [0:(1<<AW)-1];

  typedef struct packed {
    logic [31:0]   pc;
    logic [DW-1:0] inst;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  assign imem_inst = rom[imem_addr];

  imem_fetch_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt_req       (halt_req),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_inst      (imem_inst),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .busy           (busy),
    .err            (err)
`ifdef IMEM_FETCH_PERF_EN
    ,
    .fetch_count    (fetch_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected instruction for a byte PC, taken from the bench's own ROM image.
  task automatic push(input logic [31:0] pc);
    logic [AW-1:0] idx;
    idx = pc[AW+1:2];
    exp_q.push_back('{pc: pc, inst: rom[idx]});
  endtask

  // Scoreboard: every accepted handshake must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("sb_underflow", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_pc", out_pc, e.pc);
        check("sb_inst", out_inst, e.inst);
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << AW); i++) rom[i] = 32'hA000_0000 | 32'(i);
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0; out_ready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_pc", out_pc, 32'd0);
    check("rst_inst", out_inst, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_addr", 32'(imem_addr), 32'd0);
`ifdef IMEM_FETCH_PERF_EN
    check("rst_count", fetch_count, 32'd0);
`endif
    rst_n = 1'b1;
    tick();

    // Start latency and first stream
    push(32'h0); push(32'h4); push(32'h8);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("lat_busy", 32'(busy), 32'd1);
    check("lat_valid_e1", 32'(out_valid), 32'd0);
    tick();
    check("lat_valid_e2", 32'(out_valid), 32'd1);
    check("first_pc", out_pc, 32'h0);
    check("first_inst", out_inst, 32'h11);
    tick();
    out_ready = 1'b0;

    // Backpressure holds output and PC
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_pc", out_pc, 32'h4);
      check("bp_inst", out_inst, 32'h22);
      check("bp_addr", 32'(imem_addr), 32'd2);
    end
    out_ready = 1'b1;
    tick();
    check("rel_pc", out_pc, 32'h8);
    check("rel_inst", out_inst, 32'h33);

    // Aligned redirect while out_valid is high
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    check("redir_valid", 32'(out_valid), 32'd0);
    check("redir_busy", 32'(busy), 32'd1);
    check("redir_addr", 32'(imem_addr), 32'd64);
    push(32'h100);
    tick();
    check("redir_out_pc", out_pc, 32'h100);
    check("redir_out_inst", out_inst, 32'hA000_0040);
    tick();
    out_ready = 1'b0;
    check("stall_pc", out_pc, 32'h104);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h102;
    tick();
    redirect_valid = 1'b0;
    check("mis_err", 32'(err), 32'd1);
    check("mis_busy", 32'(busy), 32'd0);
    check("mis_valid", 32'(out_valid), 32'd0);
    check("mis_addr", 32'(imem_addr), 32'd66);
    tick();
    check("mis_err_sticky", 32'(err), 32'd1);

    // Restart from HALT clears err and resumes at the held PC
    out_ready = 1'b1;
    push(32'h108);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("resume_err", 32'(err), 32'd0);
    check("resume_busy", 32'(busy), 32'd1);
    tick();
    check("resume_pc", out_pc, 32'h108);
    tick();
    out_ready = 1'b0;

    // Halt with a pending output: not flushed, completes its handshake
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    check("halt_busy", 32'(busy), 32'd0);
    check("halt_valid", 32'(out_valid), 32'd1);
    check("halt_pc", out_pc, 32'h10C);
    push(32'h10C);
    out_ready = 1'b1;
    tick();
    check("halt_drain_valid", 32'(out_valid), 32'd0);
    tick();
    check("halt_idle_valid", 32'(out_valid), 32'd0);

    // Start + redirect from HALT, then ROM index wrap
    push(32'hFFC); push(32'h1000);
    start = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'hFFC;
    tick();
    start = 1'b0; redirect_valid = 1'b0;
    check("wrap_busy", 32'(busy), 32'd1);
    check("wrap_addr", 32'(imem_addr), 32'd1023);
    tick();
    check("wrap_last_inst", out_inst, 32'hA000_03FF);
    tick();
    check("wrap_pc", out_pc, 32'h1000);
    check("wrap_inst", out_inst, 32'h11);
    tick();
    out_ready = 1'b0;
    check("wrap_next_addr", 32'(imem_addr), 32'd2);

    // Asynchronous mid-stream reset
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(out_valid), 32'd0);
    check("arst_pc", out_pc, 32'd0);
    check("arst_inst", out_inst, 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_err", 32'(err), 32'd0);
`ifdef IMEM_FETCH_PERF_EN
    check("arst_count", fetch_count, 32'd0);
`endif
    tick();
    rst_n = 1'b1;
    tick();

    // Start + halt from IDLE: start wins; exactly 5 accepted handshakes
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(32'(i * 4));
    start = 1'b1; halt_req = 1'b1;
    tick();
    start = 1'b0; halt_req = 1'b0;
    check("sh_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 6; i++) tick();
    out_ready = 1'b0;
    check("five_pc", out_pc, 32'h14);
    tick();
`ifdef IMEM_FETCH_PERF_EN
    check("perf_count", fetch_count, 32'd5);
`endif
    check("sb_drain", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_imem_fetch_ctrl
